// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus arbiter slice.
// Widths, source count, source indices and round-robin helper.
package cdb_pkg;

  localparam int VREG_W  = 5;
  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 3;

  typedef logic [1:0] src_t;

  localparam src_t SRC_ALU = 2'd0;
  localparam src_t SRC_LSB = 2'd1;
  localparam src_t SRC_BR  = 2'd2;

  // Next source index, modulo NUM_SRC.
  function automatic src_t next_src(input src_t s);
    return (s == SRC_BR) ? SRC_ALU : src_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO feeding the CDB arbiter.
// Ports: i_push/i_push_data in, i_pop in, o_head_data/o_empty/o_full out, i_flush clears.
module cdb_src_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head_data,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push)
                         - (AW+1)'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_push_data;
  end

  assign o_head_data = r_mem[r_rptr];
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB among ALU, LSB and branch unit.
// Ports: srcK_valid/vregid/val in, srcK_ready out, cdb_en/vregid/val out, busy out.
module cdb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int VREG_W = cdb_pkg::VREG_W,
  parameter int DATA_W = cdb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [VREG_W-1:0] src0_vregid,
  input  logic [DATA_W-1:0] src0_val,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [VREG_W-1:0] src1_vregid,
  input  logic [DATA_W-1:0] src1_val,
  input  logic              src2_valid,
  output logic              src2_ready,
  input  logic [VREG_W-1:0] src2_vregid,
  input  logic [DATA_W-1:0] src2_val,
  output logic              cdb_en,
  output logic [VREG_W-1:0] cdb_vregid,
  output logic [DATA_W-1:0] cdb_val,
  output logic              busy
);

  import cdb_pkg::*;

  localparam int EW = VREG_W + DATA_W;

  logic [NUM_SRC-1:0] w_valid;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_full;
  logic [EW-1:0]      w_push_data [NUM_SRC];
  logic [EW-1:0]      w_head      [NUM_SRC];

  src_t r_rr_last;
  src_t w_win;
  src_t w_cand;
  logic w_win_vld;

  assign w_valid = {src2_valid, src1_valid, src0_valid};

  assign w_push_data[0] = {src0_vregid, src0_val};
  assign w_push_data[1] = {src1_vregid, src1_val};
  assign w_push_data[2] = {src2_vregid, src2_val};

  // Ready comes from registered fullness only; no same-cycle pop bypass.
  assign src0_ready = ~w_full[0];
  assign src1_ready = ~w_full[1];
  assign src2_ready = ~w_full[2];

  // Pushes in a flush cycle are dropped.
  assign w_push = w_valid & ~w_full & {NUM_SRC{~flush}};

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fifo
    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (flush),
      .i_push      (w_push[k]),
      .i_push_data (w_push_data[k]),
      .i_pop       (w_pop[k]),
      .o_head_data (w_head[k]),
      .o_empty     (w_empty[k]),
      .o_full      (w_full[k])
    );
  end

  // Scan rr_last+1, +2, +3 (mod 3); first non-empty head wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = r_rr_last;
    w_cand    = r_rr_last;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_cand = next_src(w_cand);
      if (!w_win_vld && !w_empty[w_cand]) begin
        w_win_vld = 1'b1;
        w_win     = w_cand;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_win_vld) w_pop[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_en     <= 1'b0;
      cdb_vregid <= '0;
      cdb_val    <= '0;
      r_rr_last  <= SRC_BR;
    end else if (flush) begin
      cdb_en <= 1'b0;
    end else begin
      cdb_en <= w_win_vld;
      if (w_win_vld) begin
        {cdb_vregid, cdb_val} <= w_head[w_win];
        r_rr_last             <= w_win;
      end
    end
  end

  assign busy = (~&w_empty) | cdb_en;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
// Scoreboard tracks per-source order, ready and busy every cycle.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  v;
  logic [2:0]  rdy;
  logic [4:0]  vr [3];
  logic [31:0] dv [3];
  logic        cdb_en;
  logic [4:0]  cdb_vregid;
  logic [31:0] cdb_val;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  logic [36:0] q [3][$];
  int pushed [3];
  int popped [3];
  int bcnt   [3];
  int gap    [3];
  int maxgap [3];
  int seq    [3];
  logic [31:0] base [3];
  logic saw_full [3];

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .src0_valid  (v[0]),
    .src0_ready  (rdy[0]),
    .src0_vregid (vr[0]),
    .src0_val    (dv[0]),
    .src1_valid  (v[1]),
    .src1_ready  (rdy[1]),
    .src1_vregid (vr[1]),
    .src1_val    (dv[1]),
    .src2_valid  (v[2]),
    .src2_ready  (rdy[2]),
    .src2_vregid (vr[2]),
    .src2_val    (dv[2]),
    .cdb_en      (cdb_en),
    .cdb_vregid  (cdb_vregid),
    .cdb_val     (cdb_val),
    .busy        (busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    int hit;
    logic [36:0] ent;
    logic any;
    for (int k = 0; k < 3; k++)
      if (!rst && !flush && v[k] && rdy[k]) begin
        q[k].push_back({vr[k], dv[k]});
        pushed[k]++;
      end
    @(posedge clk);
    @(negedge clk);
    if (rst || flush)
      for (int k = 0; k < 3; k++) begin
        q[k].delete();
        pushed[k] = 0;
        popped[k] = 0;
      end
    if (cdb_en) begin
      ent = {cdb_vregid, cdb_val};
      hit = -1;
      for (int k = 0; k < 3; k++)
        if (hit < 0 && q[k].size() > 0 && q[k][0] == ent)
          hit = k;
      check("cdb_entry", 64'(hit >= 0), 64'd1);
      if (hit >= 0) begin
        void'(q[hit].pop_front());
        popped[hit]++;
        bcnt[hit]++;
        for (int k = 0; k < 3; k++)
          if (k == hit) gap[k] = 0;
          else begin
            gap[k]++;
            if (gap[k] > maxgap[k]) maxgap[k] = gap[k];
          end
      end
    end
    any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("ready", 64'(rdy[k]),
            64'((pushed[k] - popped[k]) < 4));
      if (pushed[k] - popped[k] == 4) saw_full[k] = 1'b1;
      if (pushed[k] - popped[k] > 0) any = 1'b1;
    end
    check("busy", 64'(busy), 64'(any || cdb_en));
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    flush = 1'b0;
    v     = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      seq[k]      = 0;
      bcnt[k]     = 0;
      gap[k]      = 0;
      maxgap[k]   = 0;
      saw_full[k] = 1'b0;
    end
  endtask

  task automatic stream(input logic [2:0] mask, input int n);
    logic [2:0] acc;
    repeat (n) begin
      v = mask;
      for (int k = 0; k < 3; k++) begin
        vr[k] = 5'(seq[k]);
        dv[k] = base[k] + 32'(seq[k]);
      end
      acc = v & rdy;
      tick();
      for (int k = 0; k < 3; k++)
        if (acc[k]) seq[k]++;
    end
  endtask

  task automatic drain;
    v = '0;
    for (int i = 0; i < 40 && (busy || cdb_en); i++)
      tick();
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_q", 64'(q[0].size() + q[1].size()
                         + q[2].size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    v     = '0;
    for (int k = 0; k < 3; k++) begin
      vr[k]     = '0;
      dv[k]     = '0;
      pushed[k] = 0;
      popped[k] = 0;
    end
    base[0] = 32'h0A00_0000;
    base[1] = 32'h0B00_0000;
    base[2] = 32'h0C00_0000;

    // Reset state
    do_reset();
    check("rst_en", 64'(cdb_en), 64'd0);
    check("rst_vreg", 64'(cdb_vregid), 64'd0);
    check("rst_val", 64'(cdb_val), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdy", 64'(rdy), 64'h7);

    // Single source, 2-cycle latency
    v     = 3'b001;
    vr[0] = 5'd3;
    dv[0] = 32'hDEAD_BEEF;
    tick();
    v = '0;
    check("t1_c2_en", 64'(cdb_en), 64'd0);
    tick();
    check("t1_c3_en", 64'(cdb_en), 64'd1);
    check("t1_c3_vreg", 64'(cdb_vregid), 64'd3);
    check("t1_c3_val", 64'(cdb_val), 64'hDEAD_BEEF);
    tick();
    check("t1_c4_en", 64'(cdb_en), 64'd0);
    check("t1_c4_busy", 64'(busy), 64'd0);

    // Simultaneous pushes, two rounds, src0 first each time
    do_reset();
    for (int r = 0; r < 2; r++) begin
      v = 3'b111;
      for (int k = 0; k < 3; k++) begin
        vr[k] = 5'(1 + 3 * r + k);
        dv[k] = 32'(256 + 16 * r + k);
      end
      tick();
      v = '0;
      check("t2_gap_en", 64'(cdb_en), 64'd0);
      for (int k = 0; k < 3; k++) begin
        tick();
        check("t2_en", 64'(cdb_en), 64'd1);
        check("t2_vreg", 64'(cdb_vregid), 64'(1 + 3 * r + k));
      end
      tick();
      check("t2_idle", 64'(cdb_en), 64'd0);
    end

    // Backpressure: src1 fills while sharing the bus
    do_reset();
    stream(3'b111, 24);
    check("bp_full_seen", 64'(saw_full[1]), 64'd1);
    drain();

    // Fairness over 30 saturated cycles
    do_reset();
    stream(3'b111, 30);
    for (int k = 0; k < 3; k++) begin
      check("fair_cnt", 64'(bcnt[k] >= 9 && bcnt[k] <= 11), 64'd1);
      check("fair_gap", 64'(maxgap[k] <= 2), 64'd1);
    end
    drain();

    // Flush with queued entries and a same-cycle push
    do_reset();
    stream(3'b111, 2);
    flush = 1'b1;
    v     = 3'b111;
    for (int k = 0; k < 3; k++) begin
      vr[k] = 5'd31;
      dv[k] = 32'hFFFF_0000 + 32'(k);
    end
    tick();
    flush = 1'b0;
    v     = '0;
    check("fl_en", 64'(cdb_en), 64'd0);
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_rdy", 64'(rdy), 64'h7);
    repeat (6) tick();
    check("fl_en_late", 64'(cdb_en), 64'd0);
    check("fl_busy_late", 64'(busy), 64'd0);

    // Wrap/full: src2 sends 0..7 while competing
    do_reset();
    base[2] = 32'd0;
    for (int i = 0; i < 60 && seq[2] < 8; i++) begin
      if (seq[2] < 8) stream(3'b111, 1);
    end
    v = '0;
    check("wr_pushes", 64'(seq[2]), 64'd8);
    drain();
    check("wr_full_seen", 64'(saw_full[2]), 64'd1);
    check("wr_bcnt", 64'(bcnt[2]), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
